// File: rtl/core_pkg.sv
// core_pkg: shared load/store encodings, FSM state type and byte-enable type for the LSU
package core_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b011;
    localparam logic [2:0] MEM_LHU = 3'b100;
    localparam logic [2:0] MEM_SB  = 3'b101;
    localparam logic [2:0] MEM_SH  = 3'b110;
    localparam logic [2:0] MEM_SW  = 3'b111;

    typedef enum logic [1:0] {IDLE, REQ, WAITR, RESP} lsu_state_t;

    typedef logic [3:0] byte_en_t;

    // 0 = byte, 1 = halfword, 2 = word
    function automatic logic [1:0] access_size(input logic [2:0] ctrl);
        return (ctrl == MEM_LW || ctrl == MEM_SW) ? 2'd2 :
               (ctrl == MEM_LH || ctrl == MEM_LHU || ctrl == MEM_SH) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the raw memory word down to the addressed lane and extends it
module lsu_load_align
    import core_pkg::*;
(
    input  logic [31:0] rdata_raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  ctrl,
    output logic [31:0] result
);

    logic [31:0] s;

    assign s = rdata_raw >> {offset, 3'b000};

    always_comb begin
        result = (ctrl == MEM_LB)  ? {{24{s[7]}}, s[7:0]}   :
                 (ctrl == MEM_LH)  ? {{16{s[15]}}, s[15:0]} :
                 (ctrl == MEM_LBU) ? {24'b0, s[7:0]}        :
                 (ctrl == MEM_LHU) ? {16'b0, s[15:0]}       : s;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit back end driving a req/gnt/rvalid data-memory port
module lsu_mem_ctrl
    import core_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          memValid,
    input  logic          memWR,
    input  logic [2:0]    memCtrl,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          misaligned,
    output logic          busErr,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [3:0]    dmem_be,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    input  logic [31:0]   dmem_rdata
);

    lsu_state_t  state, nxt;
    logic        we_q, mis_q, err_q;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q, sz;
    logic [31:0] cnt, ext, wd_n;
    byte_en_t    be_n;
    logic        bad, tmo, accept, hit;

    assign sz     = access_size(memCtrl);
    assign bad    = (memWR != (memCtrl >= MEM_SB)) || (sz == 2'd1 && addr[0]) ||
                    (sz == 2'd2 && addr[1:0] != 2'b00);
    assign accept = state == IDLE && memValid;
    assign tmo    = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
    assign hit    = (state == REQ && dmem_gnt && !we_q && dmem_rvalid) || (state == WAITR && dmem_rvalid);
    assign be_n   = sz == 2'd2 ? 4'b1111 : (sz == 2'd1 ? 4'b0011 : 4'b0001) << addr[1:0];
    assign wd_n   = sz == 2'd2 ? wdata : sz == 2'd1 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};

    lsu_load_align u_align (
        .rdata_raw (dmem_rdata),
        .offset    (off_q),
        .ctrl      (ctrl_q),
        .result    (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  nxt = memValid ? (bad ? RESP : REQ) : IDLE;
            REQ:   nxt = dmem_gnt ? ((we_q || dmem_rvalid) ? RESP : WAITR) : (tmo ? RESP : REQ);
            WAITR: nxt = (dmem_rvalid || tmo) ? RESP : WAITR;
            RESP:  nxt = IDLE;
        endcase
    end

    always_comb begin
        stall      = accept || state == REQ || state == WAITR;
        done       = state == RESP;
        misaligned = done && mis_q;
        busErr     = done && err_q;
        dmem_req   = state == REQ;
        dmem_we    = dmem_req && we_q;
    end

    // Any exit from REQ/WAITR into RESP that is not a grant or read return is a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            ctrl_q     <= '0;
            off_q      <= '0;
            rdata      <= '0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            cnt <= (nxt != state) ? '0 : (state == REQ || state == WAITR) ? cnt + 32'd1 : cnt;
            if (accept) begin
                we_q   <= memWR;
                ctrl_q <= memCtrl;
                off_q  <= addr[1:0];
                mis_q  <= bad;
                err_q  <= 1'b0;
                if (bad) begin
                    rdata <= '0;
                end else begin
                    dmem_be    <= be_n;
                    dmem_addr  <= {addr[AW-1:2], 2'b00};
                    dmem_wdata <= wd_n;
                end
            end
            if (hit) begin
                rdata <= ext;
            end else if (state == REQ && dmem_gnt && we_q) begin
                rdata <= '0;
            end else if ((state == REQ || state == WAITR) && nxt == RESP) begin
                err_q <= 1'b1;
                rdata <= '0;
            end
        end
    end

endmodule
